onehot_mux_bank: RTL and testbench
==================================

Name: onehot_mux_bank

Overview:
- Registered one-hot-select N:1 bit multiplexer.
- Five independent select-logic styles feed five outputs: ternary chain, case, if/else chain, for-loop, and AND-OR reduction.
- Each output is registered separately.
- Used as a reference/cross-check block: all five outputs must always agree, and an error flag reports illegal select codes.

Parameters:
- NUM_IN, 4, number of data inputs and select bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- a_i  input  NUM_IN  data bits; bit k is selected when sel_i[k]=1.
- sel_i  input  NUM_IN  one-hot select.
- y_ter_o  output  1  registered result, nested-ternary implementation.
- y_case_o  output  1  registered result, case implementation.
- y_ifelse_o  output  1  registered result, if/else-if priority chain.
- y_loop_o  output  1  registered result, for-loop implementation.
- y_aor_o  output  1  registered result, AND-OR reduction: |(a_i & sel_i).
- sel_err_o  output  1  registered flag: sel_i was not exactly one-hot.

Behaviour:
- One clock and one reset. Reset is synchronous and active-low: when reset_n=0 at a rising clk edge, all six outputs become 0 on that edge.
- Latency is one cycle. Outputs at edge n+1 reflect a_i/sel_i sampled at edge n. There is no handshake; a new input is accepted every cycle.
- Legal select: sel_i has exactly one bit set, at index k.
  - All five y_* outputs register a_i[k].
  - sel_err_o registers 0.
- Illegal select (sel_i all-zero, or two or more bits set):
  - All five y_* outputs register 0. Each style must be gated by the one-hot-valid signal so no style leaks its natural priority or OR behaviour.
  - sel_err_o registers 1.
- Invariant: y_ter_o == y_case_o == y_ifelse_o == y_loop_o == y_aor_o in every cycle, including reset and illegal selects.
- Ternary and if/else chains are written in index order 0..NUM_IN-1. Case uses one-hot constant items with a default of 0. The loop scans every bit.
- All combinational paths are fully assigned; no latches.
- X/Z on inputs is not handled specially.
- Reset asserted mid-stream clears outputs on that edge, regardless of inputs. The first post-reset result appears one cycle after reset_n returns high.

Decomposition:
- Shared package onehot_mux_pkg holds:
  - default NUM_IN constant (4);
  - function is_onehot(vec), returns 1 when exactly one bit is set;
  - function onehot_to_idx(vec).
- One natural sub-module: onehot_chk, combinational. Input sel_i, outputs valid and idx. It is instantiated once and shared by all five styles.
- Output registers live in the top module.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with a_i=4'b1111, sel_i=4'b0001 -> all outputs 0. Release reset; next edge gives all y_*=1, sel_err_o=0.
- Legal selects, a_i=4'b0011, one cycle apart:
  - sel_i=4'b0010 -> all y_*=1.
  - then sel_i=4'b1000 -> all y_*=0.
  - then sel_i=4'b0001 -> all y_*=1.
  - Each result appears one cycle after the inputs; sel_err_o=0 throughout.
- Illegal selects, a_i=4'b1111:
  - sel_i=4'b0000 -> all y_*=0, sel_err_o=1.
  - sel_i=4'b0110 -> all y_*=0, sel_err_o=1.
- Exhaustive sweep: all 16 a_i values x 4 one-hot sel_i values -> y_* == a_i[k], all five equal every cycle. Then all 16 sel_i values at a_i=4'b1010 -> sel_err_o=1 exactly for the 12 non-one-hot codes.
- Mid-stream reset: toggle inputs every cycle, assert reset_n=0 for one edge -> outputs 0 on that edge, valid results resume one cycle after release.
- Parameter check: NUM_IN=8, a_i=8'h80, sel_i=8'h80 -> all y_*=1. Then sel_i=8'h01 -> all y_*=0.

Source files
------------

// File: rtl/onehot_mux_pkg.sv
// rtl/onehot_mux_pkg.sv - shared constants and one-hot helper functions for onehot_mux_bank
package onehot_mux_pkg;

    localparam int NUM_IN_DEFAULT = 4;
    localparam int MAX_IN         = 16;

    function automatic logic is_onehot(input logic [MAX_IN-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int k = 0; k < MAX_IN; k++) begin
            cnt += 32'(vec[k]);
        end
        return (cnt == 1);
    endfunction

    // Only meaningful when vec is one-hot; OR-ing indices gives k directly.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_IN-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int k = 0; k < MAX_IN; k++) begin
            if (vec[k]) begin
                idx = idx | 4'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_mux_bank_chk.sv
// rtl/onehot_mux_bank_chk.sv - combinational one-hot validity and index decode shared by all select styles
module onehot_chk
    import onehot_mux_pkg::*;
#(
    parameter  int NUM_IN = NUM_IN_DEFAULT,
    localparam int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] sel_i,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        valid = is_onehot(MAX_IN'(sel_i));
        idx   = IDX_W'(onehot_to_idx(MAX_IN'(sel_i)));
    end

endmodule

// File: rtl/onehot_mux_bank.sv
// rtl/onehot_mux_bank.sv - registered one-hot N:1 bit mux built five ways, with illegal-select flag
module onehot_mux_bank
    import onehot_mux_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IN-1:0] a_i,
    input  logic [NUM_IN-1:0] sel_i,
    output logic              y_ter_o,
    output logic              y_case_o,
    output logic              y_ifelse_o,
    output logic              y_loop_o,
    output logic              y_aor_o,
    output logic              sel_err_o
);

    localparam int IDX_W = $clog2(NUM_IN);

    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [NUM_IN:0]  ter_chain;
    logic [MAX_IN-1:0] a_ext;
    logic [MAX_IN-1:0] sel_ext;
    logic ter_d, case_d, ifelse_d, loop_d, aor_d;

    onehot_chk #(.NUM_IN(NUM_IN)) u_chk (
        .sel_i (sel_i),
        .valid (valid),
        .idx   (idx)
    );

    assign a_ext   = MAX_IN'(a_i);
    assign sel_ext = MAX_IN'(sel_i);

    // Nested ternary, bit 0 outermost.
    assign ter_chain[NUM_IN] = 1'b0;
    for (genvar k = 0; k < NUM_IN; k++) begin : g_ter
        assign ter_chain[k] = sel_i[k] ? a_i[k] : ter_chain[k+1];
    end

    always_comb begin
        ter_d = valid ? ter_chain[0] : 1'b0;
    end

    always_comb begin
        case_d = 1'b0;
        case (sel_ext)
            16'h0001: case_d = a_ext[0];
            16'h0002: case_d = a_ext[1];
            16'h0004: case_d = a_ext[2];
            16'h0008: case_d = a_ext[3];
            16'h0010: case_d = a_ext[4];
            16'h0020: case_d = a_ext[5];
            16'h0040: case_d = a_ext[6];
            16'h0080: case_d = a_ext[7];
            16'h0100: case_d = a_ext[8];
            16'h0200: case_d = a_ext[9];
            16'h0400: case_d = a_ext[10];
            16'h0800: case_d = a_ext[11];
            16'h1000: case_d = a_ext[12];
            16'h2000: case_d = a_ext[13];
            16'h4000: case_d = a_ext[14];
            16'h8000: case_d = a_ext[15];
            default:  case_d = 1'b0;
        endcase
        if (!valid) begin
            case_d = 1'b0;
        end
    end

    always_comb begin
        ifelse_d = 1'b0;
        if      (sel_ext[0])  ifelse_d = a_ext[0];
        else if (sel_ext[1])  ifelse_d = a_ext[1];
        else if (sel_ext[2])  ifelse_d = a_ext[2];
        else if (sel_ext[3])  ifelse_d = a_ext[3];
        else if (sel_ext[4])  ifelse_d = a_ext[4];
        else if (sel_ext[5])  ifelse_d = a_ext[5];
        else if (sel_ext[6])  ifelse_d = a_ext[6];
        else if (sel_ext[7])  ifelse_d = a_ext[7];
        else if (sel_ext[8])  ifelse_d = a_ext[8];
        else if (sel_ext[9])  ifelse_d = a_ext[9];
        else if (sel_ext[10]) ifelse_d = a_ext[10];
        else if (sel_ext[11]) ifelse_d = a_ext[11];
        else if (sel_ext[12]) ifelse_d = a_ext[12];
        else if (sel_ext[13]) ifelse_d = a_ext[13];
        else if (sel_ext[14]) ifelse_d = a_ext[14];
        else if (sel_ext[15]) ifelse_d = a_ext[15];
        if (!valid) begin
            ifelse_d = 1'b0;
        end
    end

    always_comb begin
        loop_d = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i[k]) begin
                loop_d = loop_d | a_i[k];
            end
        end
        loop_d = loop_d & valid;
    end

    always_comb begin
        aor_d = valid & (|(a_i & sel_i));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y_ter_o    <= 1'b0;
            y_case_o   <= 1'b0;
            y_ifelse_o <= 1'b0;
            y_loop_o   <= 1'b0;
            y_aor_o    <= 1'b0;
            sel_err_o  <= 1'b0;
        end else begin
            y_ter_o    <= ter_d;
            y_case_o   <= case_d;
            y_ifelse_o <= ifelse_d;
            y_loop_o   <= loop_d;
            y_aor_o    <= aor_d;
            sel_err_o  <= ~valid;
        end
    end

    // Cross-check the decoded index path against the styles in simulation.
    always_ff @(posedge clk) begin
        if (reset_n && valid) begin
            assert (aor_d == a_i[idx]);
        end
        assert ((ter_d == case_d) && (case_d == ifelse_d) &&
                (ifelse_d == loop_d) && (loop_d == aor_d));
    end

endmodule

// File: tb/tb_onehot_mux_bank.sv
// tb/tb_onehot_mux_bank.sv - table and scoreboard bench for onehot_mux_bank (NUM_IN=4 and NUM_IN=8)
module tb_onehot_mux_bank;

    typedef struct {
        logic [3:0] a;
        logic [3:0] sel;
        logic       rst_n;
        logic [5:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [5:0] exp;
        string      name;
    } sb_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] a_i;
    logic [3:0] sel_i;
    logic       y_ter, y_case, y_ifelse, y_loop, y_aor, sel_err;
    logic [7:0] a8, sel8;
    logic       y8_ter, y8_case, y8_ifelse, y8_loop, y8_aor, sel8_err;

    int passed = 0;
    int total  = 0;
    sb_t sb_q[$];
    vec_t tbl[$];

    onehot_mux_bank #(.NUM_IN(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_i        (a_i),
        .sel_i      (sel_i),
        .y_ter_o    (y_ter),
        .y_case_o   (y_case),
        .y_ifelse_o (y_ifelse),
        .y_loop_o   (y_loop),
        .y_aor_o    (y_aor),
        .sel_err_o  (sel_err)
    );

    onehot_mux_bank #(.NUM_IN(8)) dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_i        (a8),
        .sel_i      (sel8),
        .y_ter_o    (y8_ter),
        .y_case_o   (y8_case),
        .y_ifelse_o (y8_ifelse),
        .y_loop_o   (y8_loop),
        .y_aor_o    (y8_aor),
        .sel_err_o  (sel8_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] sel, input logic rn);
        if (!rn) return 6'b000000;
        if ($countones(sel) == 1) return {{5{|(a & sel)}}, 1'b0};
        return 6'b000001;
    endfunction

    task automatic check(input logic [5:0] act, input logic [5:0] exp, input string nm);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b (ter,case,ifelse,loop,aor,err)", nm, act, exp);
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] sel, input logic rn,
                         input logic [5:0] exp, input string nm);
        sb_t e;
        @(negedge clk);
        a_i = a; sel_i = sel; reset_n = rn;
        sb_q.push_back('{exp, nm});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check(6'bxxxxxx, exp, "scoreboard_empty");
        end else begin
            e = sb_q.pop_front();
            check({y_ter, y_case, y_ifelse, y_loop, y_aor, sel_err}, e.exp, e.name);
        end
    endtask

    task automatic apply8(input logic [7:0] a, input logic [7:0] sel,
                          input logic [5:0] exp, input string nm);
        @(negedge clk);
        a8 = a; sel8 = sel; reset_n = 1'b1;
        @(posedge clk);
        #1;
        check({y8_ter, y8_case, y8_ifelse, y8_loop, y8_aor, sel8_err}, exp, nm);
    endtask

    initial begin
        reset_n = 1'b0; a_i = 4'hF; sel_i = 4'b0001; a8 = 8'h00; sel8 = 8'h00;

        tbl.push_back('{4'hF, 4'b0001, 1'b0, 6'b000000, "reset_cyc0"});
        tbl.push_back('{4'hF, 4'b0001, 1'b0, 6'b000000, "reset_cyc1"});
        tbl.push_back('{4'hF, 4'b0001, 1'b1, 6'b111110, "first_after_reset"});
        tbl.push_back('{4'h3, 4'b0010, 1'b1, 6'b111110, "legal_sel1"});
        tbl.push_back('{4'h3, 4'b1000, 1'b1, 6'b000000, "legal_sel3"});
        tbl.push_back('{4'h3, 4'b0001, 1'b1, 6'b111110, "legal_sel0"});
        tbl.push_back('{4'hF, 4'b0000, 1'b1, 6'b000001, "illegal_zero"});
        tbl.push_back('{4'hF, 4'b0110, 1'b1, 6'b000001, "illegal_two"});
        tbl.push_back('{4'h5, 4'b0100, 1'b1, 6'b111110, "mid_pre"});
        tbl.push_back('{4'hA, 4'b0100, 1'b0, 6'b000000, "mid_reset"});
        tbl.push_back('{4'hA, 4'b0010, 1'b1, 6'b111110, "mid_resume"});
        tbl.push_back('{4'h5, 4'b0001, 1'b1, 6'b111110, "mid_next"});

        foreach (tbl[i]) begin
            apply(tbl[i].a, tbl[i].sel, tbl[i].rst_n, tbl[i].exp, tbl[i].name);
        end

        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < 4; k++) begin
                logic [3:0] av, sv;
                av = 4'(a);
                sv = 4'(1 << k);
                apply(av, sv, 1'b1, model(av, sv, 1'b1), $sformatf("sweep_a%0d_k%0d", a, k));
            end
        end

        for (int s = 0; s < 16; s++) begin
            logic [3:0] sv;
            sv = 4'(s);
            apply(4'hA, sv, 1'b1, model(4'hA, sv, 1'b1), $sformatf("sel_sweep_%0d", s));
        end

        for (int i = 0; i < 8; i++) begin
            logic [3:0] av, sv;
            av = 4'($urandom_range(0, 15));
            sv = 4'($urandom_range(0, 15));
            apply(av, sv, (i != 4), model(av, sv, (i != 4)), $sformatf("rand_%0d", i));
        end

        apply8(8'h80, 8'h80, 6'b111110, "n8_sel7");
        apply8(8'h80, 8'h01, 6'b000000, "n8_sel0");
        apply8(8'hFF, 8'h81, 6'b000001, "n8_illegal");
        apply8(8'h10, 8'h10, 6'b111110, "n8_sel4");

        total++;
        if (sb_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
